// File: rtl/gpio_irq_ctrl_pkg.sv
// Shared register map, AHB transfer codes and defaults for the GPIO interrupt controller.
package gpio_irq_ctrl_pkg;

  localparam int unsigned NPIN_DEF = 16;
  localparam int unsigned DBW_DEF  = 8;
  localparam int unsigned OFF_W    = 5;

  localparam logic [OFF_W-1:0] OFF_EN   = 5'h00;
  localparam logic [OFF_W-1:0] OFF_EDGE = 5'h04;
  localparam logic [OFF_W-1:0] OFF_PEND = 5'h08;
  localparam logic [OFF_W-1:0] OFF_DBNC = 5'h0C;
  localparam logic [OFF_W-1:0] OFF_RAW  = 5'h10;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // Address-phase attributes held over into the data phase.
  typedef struct packed {
    logic             sel;
    logic             write;
    logic             active;
    logic [OFF_W-1:0] addr;
  } aph_t;

  function automatic logic htrans_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One pin: two-flop synchronizer followed by a run-length debounce filter.
module gpio_debounce #(
  parameter int unsigned DBW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           pin_i,
  input  logic [DBW-1:0] dbnc_i,
  output logic           synced_o,
  output logic           filt_o
);

  logic           sync1_q, sync2_q;
  logic           filt_q, filt_d;
  logic [DBW-1:0] cnt_q, cnt_d;

  // cnt_q < dbnc_i whenever it increments, so the counter cannot pass all-ones.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q >= dbnc_i) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + DBW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign synced_o = sync2_q;
  assign filt_o   = filt_q;

endmodule

// File: rtl/gpio_irq_ctrl.sv
// AHB-Lite GPIO edge-interrupt controller: per-pin debounce, edge detect, W1C pending, level IRQ.
module gpio_irq_ctrl
  import gpio_irq_ctrl_pkg::*;
#(
  parameter int unsigned NPIN = NPIN_DEF,
  parameter int unsigned DBW  = DBW_DEF
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  input  logic            HSEL,
  input  logic            HREADY,
  input  logic            HWRITE,
  input  logic [1:0]      HTRANS,
  input  logic [2:0]      HSIZE,
  input  logic [31:0]     HADDR,
  input  logic [31:0]     HWDATA,
  output logic            HREADYOUT,
  output logic [31:0]     HRDATA,
  input  logic [NPIN-1:0] PIN_IN,
  output logic            IRQ
);

  aph_t            aph_q, aph_d;
  logic [NPIN-1:0] en_q, en_d;
  logic [NPIN-1:0] rise_q, rise_d;
  logic [NPIN-1:0] fall_q, fall_d;
  logic [NPIN-1:0] pend_q, pend_d;
  logic [NPIN-1:0] prev_q;
  logic [DBW-1:0]  dbnc_q, dbnc_d;
  logic [31:0]     hrdata_q, hrdata_d;

  logic [NPIN-1:0] synced, filt, edge_hit, w1c;
  logic            wr_commit, rd_req;
  logic [31:0]     rd_mux;
  logic            unused_ok;

  for (genvar i = 0; i < NPIN; i++) begin : g_pin
    gpio_debounce #(.DBW(DBW)) u_dbnc (
      .clk      (HCLK),
      .rst_n    (HRESETn),
      .pin_i    (PIN_IN[i]),
      .dbnc_i   (dbnc_q),
      .synced_o (synced[i]),
      .filt_o   (filt[i])
    );
  end

  assign wr_commit = aph_q.sel & aph_q.write & aph_q.active;
  assign rd_req    = HSEL & ~HWRITE & htrans_active(HTRANS) & HREADY;
  assign edge_hit  = (filt & ~prev_q & rise_q) | (~filt & prev_q & fall_q);

  // Read data is taken from the current address phase, not the captured one.
  always_comb begin
    rd_mux = '0;
    case (HADDR[OFF_W-1:0])
      OFF_EN:   rd_mux = 32'(en_q);
      OFF_EDGE: rd_mux = {16'(fall_q), 16'(rise_q)};
      OFF_PEND: rd_mux = 32'(pend_q);
      OFF_DBNC: rd_mux = 32'(dbnc_q);
      OFF_RAW:  rd_mux = {16'(filt), 16'(synced)};
      default:  rd_mux = '0;
    endcase
  end

  always_comb begin
    aph_d    = aph_q;
    en_d     = en_q;
    rise_d   = rise_q;
    fall_d   = fall_q;
    dbnc_d   = dbnc_q;
    hrdata_d = hrdata_q;
    w1c      = '0;
    if (HREADY) begin
      aph_d = '{sel: HSEL, write: HWRITE, active: htrans_active(HTRANS),
                addr: HADDR[OFF_W-1:0]};
    end
    if (rd_req) begin
      hrdata_d = rd_mux;
    end
    if (wr_commit) begin
      case (aph_q.addr)
        OFF_EN:   en_d = HWDATA[NPIN-1:0];
        OFF_EDGE: begin
          rise_d = HWDATA[NPIN-1:0];
          fall_d = HWDATA[16 +: NPIN];
        end
        OFF_PEND: w1c    = HWDATA[NPIN-1:0];
        OFF_DBNC: dbnc_d = HWDATA[DBW-1:0];
        default:  ;
      endcase
    end
    // A new edge outranks a same-cycle clear.
    pend_d = (pend_q & ~w1c) | edge_hit;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      aph_q    <= '0;
      en_q     <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      pend_q   <= '0;
      prev_q   <= '0;
      dbnc_q   <= '0;
      hrdata_q <= '0;
    end else begin
      aph_q    <= aph_d;
      en_q     <= en_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      pend_q   <= pend_d;
      prev_q   <= filt;
      dbnc_q   <= dbnc_d;
      hrdata_q <= hrdata_d;
    end
  end

  assign HREADYOUT = 1'b1;
  assign HRDATA    = hrdata_q;
  assign IRQ       = |(pend_q & en_q);
  assign unused_ok = ^{HSIZE, HADDR[31:OFF_W]};

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Scoreboard bench for gpio_irq_ctrl: directed scenarios plus randomized bus/pin traffic vs a reference model.
module tb_gpio_irq_ctrl;
  import gpio_irq_ctrl_pkg::*;

  localparam int unsigned NPIN = 16;
  localparam int unsigned DBW  = 8;

  logic            HCLK = 1'b0;
  logic            HRESETn, HSEL, HREADY, HWRITE;
  logic [1:0]      HTRANS;
  logic [2:0]      HSIZE;
  logic [31:0]     HADDR, HWDATA, HRDATA;
  logic            HREADYOUT, IRQ;
  logic [NPIN-1:0] PIN_IN;

  gpio_irq_ctrl #(.NPIN(NPIN), .DBW(DBW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY), .HWRITE(HWRITE),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HADDR(HADDR), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .PIN_IN(PIN_IN), .IRQ(IRQ)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;

  // Directed expectations: kind 0 = HRDATA, 1 = IRQ, 2 = HREADYOUT.
  typedef struct {
    string       nm;
    int          kind;
    logic [31:0] expv;
  } dchk_t;

  dchk_t       dchk_q [$];
  logic [31:0] exp_q [$];
  logic        rd_issued = 1'b0;
  logic        done = 1'b0;

  // Reference model state: architectural registers plus per-pin disagreement run lengths.
  logic [NPIN-1:0] m_en, m_rise, m_fall, m_pend, m_filt, m_prev;
  int              m_dbnc;
  int              m_run [NPIN];
  logic [NPIN-1:0] m_hist [$];
  logic            m_wr;
  logic [4:0]      m_wa;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'h00:   return 32'(m_en);
      5'h04:   return {16'(m_fall), 16'(m_rise)};
      5'h08:   return 32'(m_pend);
      5'h0C:   return 32'(m_dbnc);
      5'h10:   return {16'(m_filt), 16'(m_hist[1])};
      default: return 32'h0;
    endcase
  endfunction

  // Pin history gives the synchronized level: the value sampled two edges ago.
  always @(posedge HCLK) begin : ref_model
    logic [NPIN-1:0] syn, edges, w1c, nf;
    rd_issued = 1'b0;
    if (!HRESETn) begin
      m_en = '0; m_rise = '0; m_fall = '0; m_pend = '0; m_filt = '0; m_prev = '0;
      m_dbnc = 0; m_wr = 1'b0; m_wa = '0;
      for (int i = 0; i < NPIN; i++) m_run[i] = 0;
      m_hist.delete();
      m_hist.push_back('0);
      m_hist.push_back('0);
    end else begin
      syn = m_hist[1];
      if (HSEL && HREADY && !HWRITE && HTRANS[1]) begin
        exp_q.push_back(m_read(HADDR[4:0]));
        rd_issued = 1'b1;
      end
      edges  = (m_filt & ~m_prev & m_rise) | (~m_filt & m_prev & m_fall);
      w1c    = (m_wr && m_wa == 5'h08) ? HWDATA[NPIN-1:0] : '0;
      m_pend = (m_pend & ~w1c) | edges;
      nf = m_filt;
      for (int i = 0; i < NPIN; i++) begin
        if (syn[i] == m_filt[i]) m_run[i] = 0;
        else if (m_run[i] >= m_dbnc) begin nf[i] = syn[i]; m_run[i] = 0; end
        else m_run[i] = m_run[i] + 1;
      end
      m_prev = m_filt;
      m_filt = nf;
      if (m_wr) begin
        case (m_wa)
          5'h00: m_en = HWDATA[NPIN-1:0];
          5'h04: begin m_rise = HWDATA[NPIN-1:0]; m_fall = HWDATA[16 +: NPIN]; end
          5'h0C: m_dbnc = int'(HWDATA[DBW-1:0]);
          default: ;
        endcase
      end
      if (HREADY) begin
        m_wr = HSEL && HWRITE && HTRANS[1];
        m_wa = HADDR[4:0];
      end
      m_hist.push_front(PIN_IN);
      void'(m_hist.pop_back());
    end
  end

  always @(negedge HCLK) begin : monitor
    logic [31:0] e, act;
    dchk_t       d;
    if (rd_issued) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: HRDATA=%h with nothing expected", HRDATA);
      end else begin
        e = exp_q.pop_front();
        if (HRDATA !== e) begin
          errors++;
          $display("FAIL rd_data @%0t: HRDATA=%h expected %h", $time, HRDATA, e);
        end
      end
    end
    checks++;
    if (IRQ !== (|(m_pend & m_en))) begin
      errors++;
      $display("FAIL irq_model @%0t: IRQ=%b expected %b", $time, IRQ, |(m_pend & m_en));
    end
    while (dchk_q.size() > 0) begin
      d = dchk_q.pop_front();
      act = (d.kind == 0) ? HRDATA : (d.kind == 1) ? 32'(IRQ) : 32'(HREADYOUT);
      checks++;
      if (act !== d.expv) begin
        errors++;
        $display("FAIL %s @%0t: got %h expected %h", d.nm, $time, act, d.expv);
      end
    end
    if (done) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL rd_drain: %0d reads never observed, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  task automatic dpush(input string nm, input int kind, input logic [31:0] expv);
    dchk_t d;
    d.nm = nm; d.kind = kind; d.expv = expv;
    dchk_q.push_back(d);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] data);
    @(negedge HCLK);
    HSEL = 1'b1; HWRITE = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = {27'($urandom), a};
    @(negedge HCLK);
    HSEL = 1'b0; HWRITE = 1'b0; HTRANS = HTRANS_IDLE; HWDATA = data;
  endtask

  task automatic rd(input logic [4:0] a);
    @(negedge HCLK);
    HSEL = 1'b1; HWRITE = 1'b0; HTRANS = HTRANS_NONSEQ; HADDR = {27'($urandom), a};
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = HTRANS_IDLE;
  endtask

  task automatic rd_chk(input logic [4:0] a, input logic [31:0] expv, input string nm);
    rd(a);
    dpush(nm, 0, expv);
  endtask

  function automatic logic [4:0] pick_addr();
    logic [4:0] tbl [6] = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14};
    int k = $urandom_range(0, 6);
    return (k == 6) ? 5'($urandom) : tbl[k];
  endfunction

  initial begin : stimulus
    logic [4:0]  a;
    logic [31:0] data;
    int          b;
    HRESETn = 1'b0; HSEL = 1'b0; HREADY = 1'b1; HWRITE = 1'b0; HTRANS = HTRANS_IDLE;
    HSIZE = 3'b010; HADDR = '0; HWDATA = '0; PIN_IN = '0;
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;

    // Reset state
    rd_chk(OFF_EN, 32'h0, "rst_en");
    rd_chk(OFF_EDGE, 32'h0, "rst_edge");
    rd_chk(OFF_PEND, 32'h0, "rst_pend");
    rd_chk(OFF_DBNC, 32'h0, "rst_dbnc");
    rd_chk(OFF_RAW, 32'h0, "rst_raw");
    dpush("rst_irq", 1, 32'h0);
    dpush("hreadyout", 2, 32'h1);

    // Rise on pin 0 lands exactly 2 + (4+1) + 1 cycles after the pin change
    wr(OFF_DBNC, 32'd4);
    wr(OFF_EN, 32'h1);
    wr(OFF_EDGE, 32'h1);
    @(negedge HCLK);
    PIN_IN[0] = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(posedge HCLK); #1;
      dpush($sformatf("irq_latency_c%0d", n), 1, (n == 8) ? 32'h1 : 32'h0);
    end
    rd_chk(OFF_PEND, 32'h1, "lat_pend");

    // W1C of one of two pending bits
    wr(OFF_EN, 32'h3);
    wr(OFF_EDGE, 32'h3);
    @(negedge HCLK);
    PIN_IN[1] = 1'b1;
    repeat (10) @(negedge HCLK);
    rd_chk(OFF_PEND, 32'h3, "w1c_pre");
    wr(OFF_PEND, 32'h1);
    rd_chk(OFF_PEND, 32'h2, "w1c_post");
    dpush("w1c_irq", 1, 32'h1);

    // Three-cycle glitch on pin 3 is filtered out
    wr(OFF_PEND, 32'h3);
    wr(OFF_EN, 32'h8);
    wr(OFF_EDGE, 32'h8);
    @(negedge HCLK);
    PIN_IN[3] = 1'b1;
    repeat (3) @(negedge HCLK);
    PIN_IN[3] = 1'b0;
    repeat (12) @(negedge HCLK);
    rd_chk(OFF_PEND, 32'h0, "glitch_pend");
    rd_chk(OFF_RAW, 32'h0003_0003, "glitch_raw");
    dpush("glitch_irq", 1, 32'h0);

    // Fall edge on pin 2 sets PEND in the same cycle its W1C commits
    wr(OFF_DBNC, 32'd0);
    wr(OFF_EDGE, 32'h0004_0000);
    wr(OFF_EN, 32'h4);
    @(negedge HCLK);
    PIN_IN[2] = 1'b1;
    repeat (6) @(negedge HCLK);
    rd_chk(OFF_PEND, 32'h0, "coll_pre");
    @(negedge HCLK);
    PIN_IN[2] = 1'b0;
    @(negedge HCLK);
    wr(OFF_PEND, 32'h4);
    rd_chk(OFF_PEND, 32'h4, "coll_pend");
    dpush("coll_irq", 1, 32'h1);

    // Unmapped offset: write ignored, read returns zero
    wr(5'h14, 32'hFFFF_FFFF);
    rd_chk(5'h14, 32'h0, "unmap_rd");
    rd_chk(OFF_EN, 32'h4, "unmap_en");
    rd_chk(OFF_EDGE, 32'h0004_0000, "unmap_edge");
    rd_chk(OFF_DBNC, 32'h0, "unmap_dbnc");
    rd_chk(OFF_PEND, 32'h4, "unmap_pend");

    // Randomized traffic, checked by the reference model through the scoreboard
    for (int it = 0; it < 400; it++) begin
      @(negedge HCLK);
      if ($urandom_range(0, 2) == 0) begin
        b = $urandom_range(0, NPIN - 1);
        PIN_IN[b] = ~PIN_IN[b];
      end
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          a = pick_addr();
          data = $urandom;
          if (a == OFF_DBNC) data = {data[31:8], 8'($urandom_range(0, 5))};
          wr(a, data);
        end
        3, 4, 5: rd(pick_addr());
        6: begin
          if ($urandom_range(0, 4) == 0) begin
            HRESETn = 1'b0;
            @(negedge HCLK);
            HRESETn = 1'b1;
          end
        end
        default: repeat ($urandom_range(1, 8)) @(negedge HCLK);
      endcase
    end
    for (int k = 0; k < 5; k++) rd(5'(k * 4));
    repeat (4) @(negedge HCLK);
    done = 1'b1;
  end

endmodule
